// File: rtl/ddr_burst_sched_pkg.sv
// Shared types and helpers for the DDR burst scheduler: arbiter states and round-robin search.
package ddr_burst_sched_pkg;

    typedef enum logic [1:0] {StIdle, StReq, StWait} sched_st_e;

    localparam int unsigned MaxCh        = 8;
    localparam int unsigned DefBurstLen  = 128;
    localparam int unsigned DefBeatBytes = 8;
    localparam int unsigned BurstBytes   = DefBurstLen * DefBeatBytes;

    // First eligible channel at or after 'start', scanning n channels circularly.
    function automatic logic [2:0] rr_next(input logic [MaxCh-1:0] elig, input logic [2:0] start,
                                           input int unsigned n);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = start;
        found = 1'b0;
        for (int unsigned k = 0; k < MaxCh; k++) begin
            idx = (32'(start) + k) % n;
            if (k < n && !found && elig[idx]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ddr_burst_sched_if.sv
// Channel configuration, FIFO levels and the write/read burst-master handshakes.
interface ddr_burst_sched_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 10,
    parameter int unsigned LVL_W  = 12,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0]        ch_wr_en, ch_rd_en, pingpang, wr_restart, rd_restart;
    logic [NUM_CH*ADDR_W-1:0] wr_b_addr, wr_e_addr, rd_b_addr, rd_e_addr;
    logic [NUM_CH*LVL_W-1:0]  wr_fifo_lvl, rd_fifo_lvl;
    logic                     wr_burst_req, rd_burst_req;
    logic [ADDR_W-1:0]        wr_burst_addr, rd_burst_addr;
    logic [LEN_W-1:0]         wr_burst_len, rd_burst_len;
    logic [CH_W-1:0]          wr_burst_ch, rd_burst_ch;
    logic                     wr_ready, rd_ready, wr_burst_finish, rd_burst_finish;
    logic [NUM_CH-1:0]        wr_frame_done, rd_frame_done;

    modport master (
        input  ch_wr_en, ch_rd_en, pingpang, wr_restart, rd_restart,
        input  wr_b_addr, wr_e_addr, rd_b_addr, rd_e_addr, wr_fifo_lvl, rd_fifo_lvl,
        input  wr_ready, rd_ready, wr_burst_finish, rd_burst_finish,
        output wr_burst_req, rd_burst_req, wr_burst_addr, rd_burst_addr,
        output wr_burst_len, rd_burst_len, wr_burst_ch, rd_burst_ch, wr_frame_done, rd_frame_done
    );

    modport slave (
        output ch_wr_en, ch_rd_en, pingpang, wr_restart, rd_restart,
        output wr_b_addr, wr_e_addr, rd_b_addr, rd_e_addr, wr_fifo_lvl, rd_fifo_lvl,
        output wr_ready, rd_ready, wr_burst_finish, rd_burst_finish,
        input  wr_burst_req, rd_burst_req, wr_burst_addr, rd_burst_addr,
        input  wr_burst_len, rd_burst_len, wr_burst_ch, rd_burst_ch, wr_frame_done, rd_frame_done
    );
endinterface

// File: rtl/ddr_burst_sched_addr_gen.sv
// Per-channel, per-direction burst address generator with window wrap, ping-pong banks,
// deferred restart and a record of the last completed bank.
module ddr_burst_sched_addr_gen #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned BURST_BYTES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] end_i,
    input  logic              pingpang_i,
    input  logic              granted_i,
    input  logic              advance_i,
    input  logic              restart_i,
    input  logic              jump_i,
    input  logic              jump_bank_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              wrap_o,
    output logic              bank_o,
    output logic              done_bank_o
);
    localparam logic [ADDR_W-1:0] Step = ADDR_W'(BURST_BYTES);

    logic [ADDR_W-1:0] addr_q, addr_d, span, bank_e, nxt;
    logic              bank_q, bank_d, pend_q, pend_d, wrap_q, wrap_d, done_q, done_d;

    always_comb begin
        span   = end_i - base_i;
        bank_e = bank_q ? end_i + span : end_i;
        nxt    = addr_q + Step;
        addr_d = addr_q;
        bank_d = bank_q;
        pend_d = pend_q;
        done_d = done_q;
        wrap_d = 1'b0;
        if (restart_i && !granted_i) begin
            addr_d = base_i;
            bank_d = 1'b0;
            done_d = 1'b0;
        end else if (advance_i) begin
            if (pend_q || restart_i) begin
                addr_d = base_i;
                bank_d = 1'b0;
                pend_d = 1'b0;
                done_d = 1'b0;
            end else if (nxt + Step <= bank_e) begin
                addr_d = nxt;
            end else begin
                wrap_d = 1'b1;
                if (!pingpang_i) begin
                    addr_d = base_i;
                    bank_d = 1'b0;
                end else if (jump_i) begin
                    // Reader follows the bank the writer finished most recently.
                    bank_d = jump_bank_i;
                    addr_d = jump_bank_i ? end_i : base_i;
                end else begin
                    bank_d = !bank_q;
                    addr_d = bank_q ? base_i : end_i;
                    done_d = bank_q;
                end
            end
        end else if (restart_i) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= base_i;
            bank_q <= 1'b0;
            pend_q <= 1'b0;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            bank_q <= bank_d;
            pend_q <= pend_d;
            wrap_q <= wrap_d;
            done_q <= done_d;
        end
    end

    assign addr_o      = addr_q;
    assign wrap_o      = wrap_q;
    assign bank_o      = bank_q;
    assign done_bank_o = done_q;
endmodule

// File: rtl/ddr_burst_sched.sv
// NUM_CH-channel DDR burst scheduler: independent round-robin write and read arbiters
// feeding the AXI burst masters, with per-channel address generators.
module ddr_burst_sched
    import ddr_burst_sched_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LEN_W      = 10,
    parameter int unsigned BURST_LEN  = DefBurstLen,
    parameter int unsigned BEAT_BYTES = DefBeatBytes,
    parameter int unsigned LVL_W      = 12,
    parameter int unsigned RD_DEPTH   = 1024,
    parameter int unsigned RD_MARGIN  = 24
) (
    input logic                ui_clk,
    input logic                ui_rst,
    ddr_burst_sched_if.master  bus
);
    localparam int unsigned      CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned      BurstB    = BURST_LEN * BEAT_BYTES;
    localparam logic [LVL_W-1:0] WrThresh  = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0] RdThresh  = LVL_W'(RD_DEPTH - RD_MARGIN - BURST_LEN);

    // Index 0 is the write side, index 1 the read side.
    sched_st_e                        state_q [2];
    logic [1:0]                       req_q;
    logic [1:0][CH_W-1:0]             ch_q, grant;
    logic [1:0][2:0]                  ptr_q, ptr_nxt;
    logic [1:0][ADDR_W-1:0]           addr_q, gaddr;
    logic [1:0][NUM_CH-1:0]           elig, granted, advance, wrap, unused_bank;
    logic [NUM_CH-1:0][ADDR_W-1:0]    wr_addr, rd_addr;
    logic [NUM_CH-1:0]                wr_done_bank, unused_rd_done;
    logic [1:0]                       ready, finish;

    assign ready  = {bus.rd_ready, bus.wr_ready};
    assign finish = {bus.rd_burst_finish, bus.wr_burst_finish};

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            elig[0][i] = bus.ch_wr_en[i] && !bus.wr_restart[i] &&
                         (bus.wr_fifo_lvl[i*LVL_W +: LVL_W] >= WrThresh);
            elig[1][i] = bus.ch_rd_en[i] && !bus.rd_restart[i] &&
                         (bus.rd_fifo_lvl[i*LVL_W +: LVL_W] <= RdThresh);
        end
        for (int d = 0; d < 2; d++) begin
            grant[d]   = CH_W'(rr_next(MaxCh'(elig[d]), ptr_q[d], NUM_CH));
            ptr_nxt[d] = 3'((32'(ch_q[d]) + 32'd1) % NUM_CH);
        end
        gaddr[0] = wr_addr[grant[0]];
        gaddr[1] = rd_addr[grant[1]];
    end

    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            for (int d = 0; d < 2; d++) begin
                state_q[d] <= StIdle;
            end
            req_q  <= '0;
            ch_q   <= '0;
            ptr_q  <= '0;
            addr_q <= '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                case (state_q[d])
                    StIdle: if (ready[d] && |elig[d]) begin
                        state_q[d] <= StReq;
                        req_q[d]   <= 1'b1;
                        ch_q[d]    <= grant[d];
                        addr_q[d]  <= gaddr[d];
                    end
                    StReq: begin
                        state_q[d] <= StWait;
                        req_q[d]   <= 1'b0;
                    end
                    StWait: if (finish[d]) begin
                        state_q[d] <= StIdle;
                        ptr_q[d]   <= ptr_nxt[d];
                    end
                    default: state_q[d] <= StIdle;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        for (genvar d = 0; d < 2; d++) begin : g_dir
            assign granted[d][i] = (state_q[d] != StIdle) && (ch_q[d] == CH_W'(i));
            assign advance[d][i] = (state_q[d] == StWait) && finish[d] && (ch_q[d] == CH_W'(i));
        end

        ddr_burst_sched_addr_gen #(.ADDR_W(ADDR_W), .BURST_BYTES(BurstB)) u_wr_gen (
            .clk_i       (ui_clk),
            .rst_i       (ui_rst),
            .base_i      (bus.wr_b_addr[i*ADDR_W +: ADDR_W]),
            .end_i       (bus.wr_e_addr[i*ADDR_W +: ADDR_W]),
            .pingpang_i  (bus.pingpang[i]),
            .granted_i   (granted[0][i]),
            .advance_i   (advance[0][i]),
            .restart_i   (bus.wr_restart[i]),
            .jump_i      (1'b0),
            .jump_bank_i (1'b0),
            .addr_o      (wr_addr[i]),
            .wrap_o      (wrap[0][i]),
            .bank_o      (unused_bank[0][i]),
            .done_bank_o (wr_done_bank[i])
        );

        ddr_burst_sched_addr_gen #(.ADDR_W(ADDR_W), .BURST_BYTES(BurstB)) u_rd_gen (
            .clk_i       (ui_clk),
            .rst_i       (ui_rst),
            .base_i      (bus.rd_b_addr[i*ADDR_W +: ADDR_W]),
            .end_i       (bus.rd_e_addr[i*ADDR_W +: ADDR_W]),
            .pingpang_i  (bus.pingpang[i]),
            .granted_i   (granted[1][i]),
            .advance_i   (advance[1][i]),
            .restart_i   (bus.rd_restart[i]),
            .jump_i      (1'b1),
            .jump_bank_i (wr_done_bank[i]),
            .addr_o      (rd_addr[i]),
            .wrap_o      (wrap[1][i]),
            .bank_o      (unused_bank[1][i]),
            .done_bank_o (unused_rd_done[i])
        );
    end

    assign bus.wr_burst_req  = req_q[0];
    assign bus.rd_burst_req  = req_q[1];
    assign bus.wr_burst_addr = addr_q[0];
    assign bus.rd_burst_addr = addr_q[1];
    assign bus.wr_burst_ch   = ch_q[0];
    assign bus.rd_burst_ch   = ch_q[1];
    assign bus.wr_burst_len  = LEN_W'(BURST_LEN);
    assign bus.rd_burst_len  = LEN_W'(BURST_LEN);
    assign bus.wr_frame_done = wrap[0];
    assign bus.rd_frame_done = wrap[1];
endmodule

// File: tb/tb_ddr_burst_sched.sv
// Directed bench for ddr_burst_sched: eligibility table plus round-robin, wrap, ping-pong,
// restart and reset sequences with a simple burst-master model.
module tb_ddr_burst_sched;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    bit   seen;

    always #5 clk = ~clk;

    ddr_burst_sched_if #(.NUM_CH(2), .ADDR_W(32), .LEN_W(10), .LVL_W(12), .CH_W(1)) bus ();

    ddr_burst_sched #(.NUM_CH(2)) dut (
        .ui_clk (clk),
        .ui_rst (rst),
        .bus    (bus)
    );

    typedef struct {
        bit          rd;
        logic [1:0]  en;
        logic [11:0] lvl0;
        logic [11:0] lvl1;
        bit          exp_req;
        logic        exp_ch;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic req_of(input bit rd);
        return rd ? bus.rd_burst_req : bus.wr_burst_req;
    endfunction

    function automatic logic [31:0] addr_of(input bit rd);
        return rd ? bus.rd_burst_addr : bus.wr_burst_addr;
    endfunction

    function automatic logic ch_of(input bit rd);
        return rd ? bus.rd_burst_ch : bus.wr_burst_ch;
    endfunction

    function automatic logic [1:0] fd_of(input bit rd);
        return rd ? bus.rd_frame_done : bus.wr_frame_done;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_req(input bit rd, output bit got);
        got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clk);
            got = req_of(rd);
        end
    endtask

    // Called with the request visible; plays the master through finish.
    task automatic burst_body(input bit rd, input logic ch, input logic [31:0] a, input bit fd,
                              input bit rs, input string tag);
        chk({tag, "_ch"}, 32'(ch_of(rd)), 32'(ch));
        chk({tag, "_addr"}, addr_of(rd), a);
        @(negedge clk);
        chk({tag, "_req_pulse"}, 32'(req_of(rd)), 32'd0);
        if (rd) begin
            bus.rd_burst_finish = 1'b1;
            bus.rd_restart      = rs ? (2'b01 << ch) : 2'b00;
        end else begin
            bus.wr_burst_finish = 1'b1;
            bus.wr_restart      = rs ? (2'b01 << ch) : 2'b00;
        end
        @(negedge clk);
        bus.rd_burst_finish = 1'b0;
        bus.wr_burst_finish = 1'b0;
        bus.rd_restart      = 2'b00;
        bus.wr_restart      = 2'b00;
        chk({tag, "_fd"}, 32'(fd_of(rd)), fd ? (32'd1 << ch) : 32'd0);
    endtask

    task automatic serve(input bit rd, input logic ch, input logic [31:0] a, input bit fd,
                         input bit rs, input string tag);
        bit got;
        wait_req(rd, got);
        chk({tag, "_seen"}, 32'(got), 32'd1);
        if (got) burst_body(rd, ch, a, fd, rs, tag);
    endtask

    initial begin
        rst                 = 1'b1;
        bus.ch_wr_en        = '0;
        bus.ch_rd_en        = '0;
        bus.pingpang        = '0;
        bus.wr_restart      = '0;
        bus.rd_restart      = '0;
        bus.wr_b_addr       = {32'h0000_8000, 32'h0000_1000};
        bus.wr_e_addr       = {32'h0000_A000, 32'h0000_3000};
        bus.rd_b_addr       = {32'h0004_0000, 32'h0002_0000};
        bus.rd_e_addr       = {32'h0004_2000, 32'h0002_2000};
        bus.wr_fifo_lvl     = '0;
        bus.rd_fifo_lvl     = {12'd1000, 12'd1000};
        bus.wr_ready        = 1'b1;
        bus.rd_ready        = 1'b1;
        bus.wr_burst_finish = 1'b0;
        bus.rd_burst_finish = 1'b0;

        do_reset();
        @(negedge clk);
        chk("rst_wr_req", 32'(bus.wr_burst_req), 32'd0);
        chk("rst_rd_req", 32'(bus.rd_burst_req), 32'd0);
        chk("rst_wr_addr", bus.wr_burst_addr, 32'd0);
        chk("rst_rd_ch", 32'(bus.rd_burst_ch), 32'd0);
        chk("rst_fd", 32'({bus.wr_frame_done, bus.rd_frame_done}), 32'd0);

        // Single-grant eligibility vectors, each from reset.
        vt[0] = '{1'b0, 2'b11, 12'd128, 12'd0,    1'b1, 1'b0, 32'h0000_1000};
        vt[1] = '{1'b0, 2'b11, 12'd127, 12'd0,    1'b0, 1'b0, 32'h0};
        vt[2] = '{1'b0, 2'b11, 12'd0,   12'd200,  1'b1, 1'b1, 32'h0000_8000};
        vt[3] = '{1'b0, 2'b01, 12'd0,   12'd500,  1'b0, 1'b0, 32'h0};
        vt[4] = '{1'b0, 2'b11, 12'd128, 12'd128,  1'b1, 1'b0, 32'h0000_1000};
        vt[5] = '{1'b1, 2'b11, 12'd873, 12'd1000, 1'b0, 1'b0, 32'h0};
        vt[6] = '{1'b1, 2'b11, 12'd872, 12'd900,  1'b1, 1'b0, 32'h0002_0000};
        vt[7] = '{1'b1, 2'b10, 12'd0,   12'd0,    1'b1, 1'b1, 32'h0004_0000};
        for (int v = 0; v < 8; v++) begin
            bus.ch_wr_en    = vt[v].rd ? 2'b00 : vt[v].en;
            bus.ch_rd_en    = vt[v].rd ? vt[v].en : 2'b00;
            bus.wr_fifo_lvl = vt[v].rd ? 24'd0 : {vt[v].lvl1, vt[v].lvl0};
            bus.rd_fifo_lvl = vt[v].rd ? {vt[v].lvl1, vt[v].lvl0} : {12'd1000, 12'd1000};
            do_reset();
            wait_req(vt[v].rd, seen);
            chk($sformatf("vec%0d_req", v), 32'(seen), 32'(vt[v].exp_req));
            if (seen && vt[v].exp_req) begin
                chk($sformatf("vec%0d_len", v),
                    32'(vt[v].rd ? bus.rd_burst_len : bus.wr_burst_len), 32'd128);
                burst_body(vt[v].rd, vt[v].exp_ch, vt[v].exp_addr, 1'b0, 1'b0,
                           $sformatf("vec%0d", v));
            end
        end
        bus.ch_rd_en    = '0;
        bus.rd_fifo_lvl = '0;

        // Round robin with both channels ready and address advance per channel.
        bus.ch_wr_en    = 2'b11;
        bus.wr_fifo_lvl = {12'd128, 12'd128};
        do_reset();
        serve(1'b0, 1'b0, 32'h1000, 1'b0, 1'b0, "rr0");
        serve(1'b0, 1'b1, 32'h8000, 1'b0, 1'b0, "rr1");
        serve(1'b0, 1'b0, 32'h1400, 1'b0, 1'b0, "rr2");
        serve(1'b0, 1'b1, 32'h8400, 1'b0, 1'b0, "rr3");
        bus.ch_wr_en = 2'b00;

        // Single-window wrap on channel 0.
        bus.wr_b_addr   = {32'h0000_8000, 32'h0};
        bus.wr_e_addr   = {32'h0000_A000, 32'h0000_2000};
        bus.ch_wr_en    = 2'b01;
        bus.wr_fifo_lvl = {12'd0, 12'd128};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            serve(1'b0, 1'b0, 32'(k) * 32'h400, k == 7, 1'b0, $sformatf("np%0d", k));
        end
        serve(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "np_wrap");
        bus.ch_wr_en = 2'b00;

        // Ping-pong: write bank A, read wraps to A, write bank B, read wraps to B.
        bus.rd_b_addr = {32'h0004_0000, 32'h0};
        bus.rd_e_addr = {32'h0004_2000, 32'h0000_2000};
        bus.pingpang  = 2'b01;
        bus.ch_wr_en  = 2'b01;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            serve(1'b0, 1'b0, 32'(k) * 32'h400, k == 7, 1'b0, $sformatf("ppwa%0d", k));
        end
        bus.ch_wr_en = 2'b00;
        bus.ch_rd_en = 2'b01;
        for (int k = 0; k < 8; k++) begin
            serve(1'b1, 1'b0, 32'(k) * 32'h400, k == 7, 1'b0, $sformatf("ppra%0d", k));
        end
        serve(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "ppr_wrap_a");
        bus.ch_rd_en = 2'b00;
        bus.ch_wr_en = 2'b01;
        for (int k = 0; k < 8; k++) begin
            serve(1'b0, 1'b0, 32'h2000 + 32'(k) * 32'h400, k == 7, 1'b0, $sformatf("ppwb%0d", k));
        end
        serve(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "ppw_wrap_a");
        bus.ch_wr_en = 2'b00;
        bus.ch_rd_en = 2'b01;
        for (int k = 1; k < 8; k++) begin
            serve(1'b1, 1'b0, 32'(k) * 32'h400, k == 7, 1'b0, $sformatf("pprb%0d", k));
        end
        serve(1'b1, 1'b0, 32'h2000, 1'b0, 1'b0, "ppr_wrap_b");
        bus.ch_rd_en = 2'b00;
        bus.pingpang = 2'b00;

        // Restart arriving together with finish wins over the advance.
        bus.wr_b_addr = {32'h0000_8000, 32'h0000_1000};
        bus.wr_e_addr = {32'h0000_A000, 32'h0000_3000};
        bus.ch_wr_en  = 2'b01;
        do_reset();
        serve(1'b0, 1'b0, 32'h1000, 1'b0, 1'b0, "rs0");
        serve(1'b0, 1'b0, 32'h1400, 1'b0, 1'b1, "rs1");
        serve(1'b0, 1'b0, 32'h1000, 1'b0, 1'b0, "rs2");

        // Reset in the middle of a burst.
        do_reset();
        serve(1'b0, 1'b0, 32'h1000, 1'b0, 1'b0, "mr0");
        wait_req(1'b0, seen);
        chk("mr1_seen", 32'(seen), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_req", 32'(bus.wr_burst_req), 32'd0);
        chk("mr_addr", bus.wr_burst_addr, 32'd0);
        rst = 1'b0;
        serve(1'b0, 1'b0, 32'h1000, 1'b0, 1'b0, "mr_after");
        bus.ch_wr_en = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
